// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package : mips_defs
//  Shared MIPS opcode constants, exception encodings and memory-op decode
//  used by decode, EX and the MEM/WB stage.
//  Revision: 1.0 - initial release
// ============================================================================
package mips_defs;

   // Memory-class opcodes (IR[31:26])
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   // Exception code carried down to WB
   typedef enum logic [1:0] {
      EXC_NONE  = 2'b00,
      EXC_LOAD  = 2'b01,
      EXC_STORE = 2'b10
   } exc_t;

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } acc_size_t;

   typedef struct packed {
      logic      is_load;
      logic      is_store;
      acc_size_t size;
      logic      sext;
   } mem_op_t;

   // Classify an opcode into load/store, access width and extension kind.
   function automatic mem_op_t decode_mem_op(input logic [5:0] op);
      mem_op_t d;
      d = '{is_load: 1'b0, is_store: 1'b0, size: SZ_NONE, sext: 1'b0};
      case (op)
         OP_LW:   d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_WORD, sext: 1'b0};
         OP_LH:   d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_HALF, sext: 1'b1};
         OP_LHU:  d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_HALF, sext: 1'b0};
         OP_LB:   d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_BYTE, sext: 1'b1};
         OP_LBU:  d = '{is_load: 1'b1, is_store: 1'b0, size: SZ_BYTE, sext: 1'b0};
         OP_SW:   d = '{is_load: 1'b0, is_store: 1'b1, size: SZ_WORD, sext: 1'b0};
         OP_SH:   d = '{is_load: 1'b0, is_store: 1'b1, size: SZ_HALF, sext: 1'b0};
         OP_SB:   d = '{is_load: 1'b0, is_store: 1'b1, size: SZ_BYTE, sext: 1'b0};
         default: d = '{is_load: 1'b0, is_store: 1'b0, size: SZ_NONE, sext: 1'b0};
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_align.sv
`default_nettype none
// ============================================================================
//  Module  : dm_align
//  Combinational data-memory alignment: fault detection, store byte enables
//  and lane replication, and load lane selection with sign/zero extension.
//  Revision: 1.0 - initial release
// ============================================================================
module dm_align
   import mips_defs::*;
(
   input  logic [5:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic        is_load,
   output logic        is_store,
   output logic        fault,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   mem_op_t     dec;
   logic        misalign;
   logic        out_of_range;
   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   assign dec = decode_mem_op(op);

   // Fault detection, byte-enable generation and load extension
   always_comb begin
      is_load      = dec.is_load;
      is_store     = dec.is_store;
      misalign     = 1'b0;
      out_of_range = |addr[31:12];
      byte_en      = 4'b0000;
      wdata        = store_data;
      load_data    = 32'h0;
      half_sel     = addr[1] ? rdata[31:16] : rdata[15:0];
      byte_sel     = rdata[{addr[1:0], 3'b000} +: 8];

      case (dec.size)
         SZ_WORD: misalign = (addr[1:0] != 2'b00);
         SZ_HALF: misalign = addr[0];
         default: misalign = 1'b0;
      endcase

      fault = (dec.is_load | dec.is_store) & (misalign | out_of_range);

      // Store lanes: data replicated so every enabled lane sees its bytes
      if (dec.is_store && !fault) begin
         case (dec.size)
            SZ_WORD: begin
               byte_en = 4'b1111;
               wdata   = store_data;
            end
            SZ_HALF: begin
               byte_en = addr[1] ? 4'b1100 : 4'b0011;
               wdata   = {2{store_data[15:0]}};
            end
            SZ_BYTE: begin
               byte_en = 4'b0001 << addr[1:0];
               wdata   = {4{store_data[7:0]}};
            end
            default: byte_en = 4'b0000;
         endcase
      end

      // Faulting loads return zero
      if (dec.is_load && !fault) begin
         case (dec.size)
            SZ_WORD: load_data = rdata;
            SZ_HALF: load_data = {{16{dec.sext & half_sel[15]}}, half_sel};
            SZ_BYTE: load_data = {{24{dec.sext & byte_sel[7]}}, byte_sel};
            default: load_data = 32'h0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mem_wb_stage
//  MEM stage data memory (1024x32, byte-writable, async read) plus the MEM/WB
//  pipeline register with load/store fault reporting.
//  Revision: 1.0 - initial release
// ============================================================================
module mem_wb_stage
   import mips_defs::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR_M,
   input  logic [31:0] PC4_M,
   input  logic [31:0] AO_M,
   input  logic [31:0] RT_M,
   input  logic        grf_we_M,
   input  logic [4:0]  grf_wa_M,
   output logic [31:0] IR_W,
   output logic [31:0] PC4_W,
   output logic [31:0] AO_W,
   output logic [31:0] DR_W,
   output logic        grf_we_W,
   output logic [4:0]  grf_wa_W,
   output logic [1:0]  exc_W,
   output logic [31:0] DR_M
);

   localparam int DEPTH = 1024;

   // Power-up values hold everything at zero until the first clock edge
   logic [31:0] mem [DEPTH] = '{default: 32'h0};
   logic [31:0] ir_q     = 32'h0;
   logic [31:0] pc4_q    = 32'h0;
   logic [31:0] ao_q     = 32'h0;
   logic [31:0] dr_q     = 32'h0;
   logic        we_q     = 1'b0;
   logic [4:0]  wa_q     = 5'd0;
   logic [1:0]  exc_q    = 2'b00;

   logic [9:0]  word_idx;
   logic [31:0] rdata;
   logic        is_load;
   logic        is_store;
   logic        fault;
   logic [3:0]  byte_en;
   logic [31:0] wdata;
   logic [31:0] load_data;
   exc_t        exc_next;

   assign word_idx = AO_M[11:2];
   assign rdata    = mem[word_idx];

   dm_align u_align (
      .op         (IR_M[31:26]),
      .addr       (AO_M),
      .store_data (RT_M),
      .rdata      (rdata),
      .is_load    (is_load),
      .is_store   (is_store),
      .fault      (fault),
      .byte_en    (byte_en),
      .wdata      (wdata),
      .load_data  (load_data)
   );

   assign DR_M = load_data;

   // Exception code for the instruction currently in MEM
   always_comb begin
      exc_next = EXC_NONE;
      if (fault && is_store) exc_next = EXC_STORE;
      else if (fault && is_load) exc_next = EXC_LOAD;
   end

   // Data memory: reset wipes every word; faulting stores have no enables
   always_ff @(posedge clk) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // MEM/WB pipeline register
   always_ff @(posedge clk) begin
      if (!clr) begin
         ir_q  <= 32'h0;
         pc4_q <= 32'h0;
         ao_q  <= 32'h0;
         dr_q  <= 32'h0;
         we_q  <= 1'b0;
         wa_q  <= 5'd0;
         exc_q <= 2'b00;
      end else begin
         ir_q  <= IR_M;
         pc4_q <= PC4_M;
         ao_q  <= AO_M;
         dr_q  <= load_data;
         we_q  <= grf_we_M & (grf_wa_M != 5'd0) & ~(fault & is_load);
         wa_q  <= grf_wa_M;
         exc_q <= exc_next;
      end
   end

   assign IR_W     = ir_q;
   assign PC4_W    = pc4_q;
   assign AO_W     = ao_q;
   assign DR_W     = dr_q;
   assign grf_we_W = we_q;
   assign grf_wa_W = wa_q;
   assign exc_W    = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_wb_stage
//  Self-checking bench for mem_wb_stage: directed scenarios plus randomized
//  traffic compared against a word-array reference model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] IR_M, PC4_M, AO_M, RT_M;
   logic        grf_we_M;
   logic [4:0]  grf_wa_M;
   logic [31:0] IR_W, PC4_W, AO_W, DR_W, DR_M;
   logic        grf_we_W;
   logic [4:0]  grf_wa_W;
   logic [1:0]  exc_W;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [1024];

   localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101,
                          LB = 6'b100000, LBU = 6'b100100, SW = 6'b101011,
                          SH = 6'b101001, SB = 6'b101000, ADDU = 6'b000000;

   mem_wb_stage dut (
      .clk(clk), .clr(clr), .IR_M(IR_M), .PC4_M(PC4_M), .AO_M(AO_M),
      .RT_M(RT_M), .grf_we_M(grf_we_M), .grf_wa_M(grf_wa_M),
      .IR_W(IR_W), .PC4_W(PC4_W), .AO_W(AO_W), .DR_W(DR_W),
      .grf_we_W(grf_we_W), .grf_wa_W(grf_wa_W), .exc_W(exc_W), .DR_M(DR_M)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Reference: access width in bytes (0 = not a memory op)
   function automatic int acc_bytes(input logic [5:0] op);
      case (op)
         LW, SW:           return 4;
         LH, LHU, SH:      return 2;
         LB, LBU, SB:      return 1;
         default:          return 0;
      endcase
   endfunction

   function automatic bit is_ld(input logic [5:0] op);
      return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
   endfunction

   function automatic bit is_st(input logic [5:0] op);
      return (op == SW) || (op == SH) || (op == SB);
   endfunction

   function automatic bit ref_fault(input logic [5:0] op, input logic [31:0] ao);
      int n;
      n = acc_bytes(op);
      if (n == 0) return 1'b0;
      return ((ao % n) != 0) || (ao >= 32'h1000);
   endfunction

   // Reference load result from the model memory using shifts and masks
   function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] ao);
      logic [31:0] word, v;
      int sh;
      if (!is_ld(op) || ref_fault(op, ao)) return 32'h0;
      word = ref_mem[ao[11:2]];
      sh   = 8 * int'(ao[1:0]);
      v    = word >> sh;
      case (op)
         LW:  return word;
         LHU: return v & 32'h0000FFFF;
         LBU: return v & 32'h000000FF;
         LH:  return (v[15] ? 32'hFFFF0000 : 32'h0) | (v & 32'h0000FFFF);
         LB:  return (v[7]  ? 32'hFFFFFF00 : 32'h0) | (v & 32'h000000FF);
         default: return 32'h0;
      endcase
   endfunction

   task automatic ref_store(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] rt);
      logic [31:0] mask;
      int sh;
      if (!is_st(op) || ref_fault(op, ao)) return;
      sh = 8 * int'(ao[1:0]);
      case (acc_bytes(op))
         4:       mask = 32'hFFFFFFFF;
         2:       mask = 32'h0000FFFF << sh;
         default: mask = 32'h000000FF << sh;
      endcase
      ref_mem[ao[11:2]] = (ref_mem[ao[11:2]] & ~mask) | ((rt << sh) & mask);
   endtask

   // One pipeline cycle: drive, check combinational DR_M, clock, check WB
   task automatic step(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] rt,
                       input logic we, input logic [4:0] wa, input logic rst_n);
      logic [31:0] ir, pc4, e_dr;
      logic [1:0]  e_exc;
      logic        e_we, flt;
      ir  = {op, 26'($urandom)};
      pc4 = $urandom;
      IR_M = ir; PC4_M = pc4; AO_M = ao; RT_M = rt;
      grf_we_M = we; grf_wa_M = wa; clr = rst_n;
      #2;
      e_dr = ref_load(op, ao);
      flt  = ref_fault(op, ao);
      check("DR_M", DR_M, e_dr);
      e_exc = (flt && is_st(op)) ? 2'b10 : (flt && is_ld(op)) ? 2'b01 : 2'b00;
      e_we  = we && (wa != 0) && !(flt && is_ld(op));
      @(posedge clk);
      #1;
      if (!rst_n) begin
         for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
         ir = 0; pc4 = 0; ao = 0; e_dr = 0; e_we = 0; wa = 0; e_exc = 0;
      end else begin
         ref_store(op, ao, rt);
      end
      check("IR_W", IR_W, ir);
      check("PC4_W", PC4_W, pc4);
      check("AO_W", AO_W, ao);
      check("DR_W", DR_W, e_dr);
      check("grf_we_W", {31'h0, grf_we_W}, {31'h0, e_we});
      check("grf_wa_W", {27'h0, grf_wa_W}, {27'h0, wa});
      check("exc_W", {30'h0, exc_W}, {30'h0, e_exc});
   endtask

   logic [5:0]  op_tab [10] = '{LW, LH, LHU, LB, LBU, SW, SH, SB, ADDU, 6'b001111};
   logic [5:0]  rop;
   logic [31:0] rao;

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      clr = 1'b0; IR_M = 0; PC4_M = 0; AO_M = 0; RT_M = 0; grf_we_M = 0; grf_wa_M = 0;
      #1;
      // Outputs before the first edge
      check("t0_IR_W", IR_W, 32'h0);
      check("t0_DR_W", DR_W, 32'h0);
      check("t0_exc_W", {30'h0, exc_W}, 32'h0);
      check("t0_DR_M", DR_M, 32'h0);
      step(ADDU, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);

      // Word store then loads of every width
      step(SW,  32'h10, 32'h89ABCDEF, 1'b0, 5'd0, 1'b1);
      step(LW,  32'h10, 32'h0, 1'b1, 5'd8, 1'b1);
      check("sw_lw", DR_W, 32'h89ABCDEF);
      check("sw_lw_we", {31'h0, grf_we_W}, 32'h1);
      step(LB,  32'h10, 32'h0, 1'b1, 5'd9, 1'b1);
      check("lb", DR_W, 32'hFFFFFFEF);
      step(LBU, 32'h13, 32'h0, 1'b1, 5'd9, 1'b1);
      check("lbu", DR_W, 32'h00000089);
      step(LH,  32'h12, 32'h0, 1'b1, 5'd9, 1'b1);
      check("lh", DR_W, 32'hFFFF89AB);
      step(LHU, 32'h10, 32'h0, 1'b1, 5'd9, 1'b1);
      check("lhu", DR_W, 32'h0000CDEF);

      // Byte merge
      step(SB,  32'h11, 32'h55, 1'b0, 5'd0, 1'b1);
      step(LW,  32'h10, 32'h0, 1'b1, 5'd3, 1'b1);
      check("sb_merge", DR_W, 32'h89AB55EF);

      // Faults
      step(SW,  32'h12, 32'hDEADBEEF, 1'b0, 5'd0, 1'b1);
      check("sw_misalign_exc", {30'h0, exc_W}, 32'h2);
      step(LW,  32'h10, 32'h0, 1'b1, 5'd3, 1'b1);
      check("sw_misalign_nowrite", DR_W, 32'h89AB55EF);
      step(LW,  32'h2000, 32'h0, 1'b1, 5'd4, 1'b1);
      check("lw_oor_dr", DR_W, 32'h0);
      check("lw_oor_exc", {30'h0, exc_W}, 32'h1);
      check("lw_oor_we", {31'h0, grf_we_W}, 32'h0);
      step(SW,  32'h1000, 32'h11111111, 1'b0, 5'd0, 1'b1);
      step(SW,  32'hFFC, 32'hCAFEF00D, 1'b0, 5'd0, 1'b1);
      step(LW,  32'hFFC, 32'h0, 1'b1, 5'd5, 1'b1);
      check("last_word", DR_W, 32'hCAFEF00D);
      step(LW,  32'h0, 32'h0, 1'b1, 5'd5, 1'b1);
      check("oor_nowrap", DR_W, 32'h0);

      // Reset overrides a concurrent store and clears memory
      step(SW,  32'h20, 32'h1234, 1'b1, 5'd6, 1'b0);
      check("rst_ao", AO_W, 32'h0);
      step(LW,  32'h20, 32'h0, 1'b1, 5'd6, 1'b1);
      check("rst_nowrite", DR_W, 32'h0);
      step(LW,  32'h10, 32'h0, 1'b1, 5'd6, 1'b1);
      check("rst_cleared", DR_W, 32'h0);

      // Register 0 never written
      step(ADDU, 32'h0000ABCD, 32'h0, 1'b1, 5'd0, 1'b1);
      check("addu_r0_we", {31'h0, grf_we_W}, 32'h0);
      check("addu_ao", AO_W, 32'h0000ABCD);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         rop = op_tab[$urandom_range(0, 9)];
         case ($urandom_range(0, 11))
            0:       rao = $urandom;
            1:       rao = 32'h1000 | 32'($urandom_range(0, 255));
            2:       rao = 32'hF00 | 32'($urandom_range(0, 255));
            default: rao = 32'($urandom_range(0, 127));
         endcase
         step(rop, rao, $urandom, 1'($urandom), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 59) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port clr, input, 1, reset: synchronous and active-low (clr==0 at a rising clk edge resets).
REQ-003 SHALL have inputs IR_M, PC4_M, AO_M, RT_M, each 32 bits: instruction, PC+4, ALU result/address, and forwarded rt store data, all from EX/MEM.
REQ-004 SHALL have inputs grf_we_M (1 bit) and grf_wa_M (5 bits): register-file write enable and write address from EX/MEM.
REQ-005 SHALL have registered outputs IR_W, PC4_W, AO_W, DR_W (32 bits each); grf_we_W (1); grf_wa_W (5); exc_W (2 bits: 00 none, 01 load fault, 10 store fault).
REQ-006 SHALL have combinational output DR_M (32 bits): extended load data for the current MEM instruction, used by forwarding.

Function
REQ-007 SHALL contain a 1024x32 data memory, word-indexed by AO_M[11:2].
REQ-008 SHALL decode IR_M[31:26] into: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000; all other opcodes are non-memory.
REQ-009 SHALL write memory at the rising edge for a store, using byte enables: sw all 4 bytes; sh bytes {AO[1],0}+1..+0 from RT_M[15:0]; sb byte AO[1:0] from RT_M[7:0].
REQ-010 SHALL read memory combinationally; DR_M = selected byte/half, sign-extended (lb, lh) or zero-extended (lbu, lhu), or the full word (lw); DR_M = 0 for non-loads.
REQ-011 SHALL flag misalignment (lw/sw with AO[1:0]!=0; lh/lhu/sh with AO[0]!=0) and out-of-range access (AO_M[31:12]!=0).
REQ-012 SHALL, on a faulting store, suppress the memory write and set exc_W=10 at the next edge.
REQ-013 SHALL, on a faulting load, produce DR_M=0, set exc_W=01, and force grf_we_W=0.
REQ-014 SHALL, at each non-reset rising edge, register IR_M, PC4_M, AO_M, DR_M, grf_we_M and grf_wa_M into the *_W outputs, with 1-cycle latency.
REQ-015 SHALL force grf_we_W=0 whenever grf_wa_M==0.
REQ-016 SHALL treat a store as fully visible to a load at the same address in the next cycle; no same-cycle read/write hazard exists.

Reset
REQ-017 SHALL, when clr==0 at a rising edge, set all *_W outputs and exc_W to 0 and clear all 1024 memory words to 0.
REQ-018 SHALL give reset priority over a store presented in the same cycle: no write occurs.
REQ-019 SHALL hold all outputs and memory at 0 from time zero until the first edge.
REQ-020 SHALL resume normal latching at the first edge with clr==1 after reset.

Structure
REQ-021 SHALL take opcode constants and exc_W encodings from the shared mips_defs package, also used by decode and EX.
REQ-022 SHALL implement byte-enable generation and load extension in one sub-module, dm_align, which is purely combinational.
REQ-023 SHALL keep the memory array and the MEM/WB registers in mem_wb_stage.

Verification
REQ-024 sw AO=0x10, RT=0x89ABCDEF; then lw AO=0x10 -> DR_W=0x89ABCDEF, grf_we_W follows input.
REQ-025 After REQ-024: lb AO=0x10 -> 0xFFFFFFEF; lbu AO=0x13 -> 0x00000089; lh AO=0x12 -> 0xFFFF89AB; lhu AO=0x10 -> 0x0000CDEF.
REQ-026 sb AO=0x11 RT=0x55 over word 0x89ABCDEF -> next lw AO=0x10 returns 0x89AB55EF.
REQ-027 sw AO=0x12 -> memory unchanged, exc_W=10; lw AO=0x2000 -> DR_W=0, exc_W=01, grf_we_W=0.
REQ-028 clr=0 during a sw to 0x20 with RT=0x1234 -> no write, all *_W=0; later lw AO=0x20 -> DR_W=0.
REQ-029 addu with grf_wa_M=0 and grf_we_M=1 -> grf_we_W=0, and AO_W equals AO_M one cycle later.
